seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexes one shared seven_segment_display decoder across NUM_DIGITS common-anode digits.
//  - Sequences the digit pointer and drives the active-low anode strobes.
//  - Inserts a blanking gap between digits to prevent ghosting.
//  - Double-buffers host writes; new data is committed only at frame boundaries, so the display never tears.
//  - Sits between the host register interface and the board display pins.

---
 rtl/seven_seg_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Seven-segment scan controller: shares one hex decoder across NUM_DIGITS common-anode digits,
// with a blanking gap per slot and frame-boundary commit of host writes. Define SSD_LZB_EN for leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned SHOW_CYCLES  = 49984
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_busy,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  localparam int unsigned DATA_W     = 4 * NUM_DIGITS;
  localparam int unsigned MAX_CYCLES = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]       active_q, active_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    wrap_c;
  logic                    commit_c;
  logic                    lzb_c;
  logic [3:0]              nibble_c;

  // Hex to active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SSD_LZB_EN
  // Digit k>0 is a leading zero when nibbles k..NUM_DIGITS-1 are all zero
  function automatic logic leading_zero(input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] k);
    logic z;
    z = (k != '0);
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= 32'(k)) && (d[4*j +: 4] != 4'h0)) z = 1'b0;
    end
    return z;
  endfunction
`endif

  // Slot sequencing, digit pointer and write double-buffering
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wrap_c    = 1'b0;
    if (!enable) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx_d  = '0;
              wrap_c = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    commit_c     = pending_q & (wrap_c | ~enable);
    active_d     = commit_c ? shadow_q : active_q;
    shadow_d     = wr_en ? wr_data : shadow_q;
    pending_d    = wr_en | (pending_q & ~commit_c);
    frame_done_d = wrap_c;
  end

  // Output decode from the next state so an/seg move with the state register
  always_comb begin
    nibble_c = 4'h0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (IDX_W'(j) == idx_d) nibble_c = active_q[4*j +: 4];
    end
`ifdef SSD_LZB_EN
    lzb_c = leading_zero(active_q, idx_d);
`else
    lzb_c = 1'b0;
`endif
    an_d  = '1;
    seg_d = 7'h7F;
    if ((state_d == ST_SHOW) && !lzb_c) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = decode(nibble_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign wr_busy    = pending_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: frame-position reference model plus directed and random stimulus.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned B     = 2;
  localparam int unsigned S     = 5;
  localparam int unsigned SLOT  = B + S;
  localparam int unsigned FRAME = N * SLOT;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          wr_en;
  logic [4*N-1:0] wr_data;
  logic          wr_busy;
  logic          frame_done;
  logic [N-1:0]  an;
  logic [6:0]    seg;

  int n_cmp = 0;
  int n_err = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .BLANK_CYCLES(B),
    .SHOW_CYCLES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_busy   (wr_busy),
    .frame_done(frame_done),
    .an        (an),
    .seg       (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Reference model: the display is a pure function of the position within the frame
  int unsigned    m_pos;
  logic [4*N-1:0] m_active, m_shadow;
  bit             m_pending, m_fd, m_valid;
  logic [N-1:0]   exp_an;
  logic [6:0]     exp_seg;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    bit wrap, commit, dark;
    int unsigned dig;
    if (!rst_n) begin
      m_pos = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_fd = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      wrap   = enable && (m_pos % FRAME == FRAME - 1);
      commit = m_pending && (!enable || wrap);
      if (commit) m_active = m_shadow;
      if (wr_en) begin
        m_shadow  = wr_data;
        m_pending = 1'b1;
      end else if (commit) begin
        m_pending = 1'b0;
      end
      m_fd  = wrap;
      m_pos = enable ? (m_pos + 1) % FRAME : 0;
    end
    dig  = m_pos / SLOT;
    dark = (m_pos % SLOT) < B;
`ifdef SSD_LZB_EN
    if (dig > 0 && (m_active >> (4 * dig)) == 0) dark = 1'b1;
`endif
    exp_an  = dark ? '1 : ~(N'(1) << dig);
    exp_seg = dark ? 7'h7F : seg_of(4'((m_active >> (4 * dig)) & 16'hF));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("an",         32'(an),         32'(exp_an));
      check("seg",        32'(seg),        32'(exp_seg));
      check("wr_busy",    32'(wr_busy),    32'(m_pending));
      check("frame_done", 32'(frame_done), 32'(m_fd));
    end
  end

  task automatic wait_an(input logic [N-1:0] target, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (an === target) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL %s: timeout, actual an=%0h required an=%0h", name, an, target);
    end
  endtask

  task automatic wait_fd(input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL %s: timeout, actual frame_done=%0b required 1", name, frame_done);
    end
  endtask

  task automatic write(input logic [4*N-1:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_busy", 32'(wr_busy), 32'h0);
    check("reset_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1; enable = 1'b1;

    // Commit of 1234 at the frame boundary, then slot timing of digit 0
    repeat (5) @(negedge clk);
    write(16'h1234);
    check("busy_after_write", 32'(wr_busy), 32'h1);
    wait_fd(2 * FRAME, "fd_1234");
    check("busy_cleared_at_commit", 32'(wr_busy), 32'h0);
    @(negedge clk);
    check("digit0_blank2", 32'(an), 32'hF);
    wait_an(4'b1110, 4, "digit0_1234");
    check("digit0_seg_4", 32'(seg), 32'h19);
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (an !== 4'b1110) break;
      n++;
    end
    check("show_len", 32'(n), 32'(S));

    // Last write in a frame wins
    wait_fd(2 * FRAME, "fd_pre_1111");
    write(16'h1111);
    write(16'h2222);
    wait_fd(2 * FRAME, "fd_2222");
    wait_an(4'b1110, 4, "digit0_2222");
    check("digit0_seg_2", 32'(seg), 32'h24);

    // Disable mid-show of digit 2, then re-enable
    wait_an(4'b1011, 2 * FRAME, "digit2_lit");
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_an", 32'(an), 32'hF);
    check("disable_seg", 32'(seg), 32'h7F);
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (n < 10 && an !== 4'b1110) begin
      @(negedge clk);
      n++;
    end
    check("reenable_latency", 32'(n), 32'(B));

    // Write coinciding with the wrap edge
    write(16'h5555);
    wait_an(4'b0111, 2 * FRAME, "digit3_lit");
    repeat (S - 1) @(negedge clk);
    wr_en = 1'b1; wr_data = 16'h6666;
    @(negedge clk);
    wr_en = 1'b0;
    check("wrap_fd", 32'(frame_done), 32'h1);
    check("wrap_busy", 32'(wr_busy), 32'h1);
    wait_an(4'b1110, 4, "digit0_5555");
    check("digit0_seg_5", 32'(seg), 32'h12);
    wait_fd(2 * FRAME, "fd_6666");
    wait_an(4'b1110, 4, "digit0_6666");
    check("digit0_seg_6", 32'(seg), 32'h02);

    // Leading-zero pattern 0050
    write(16'h0050);
    wait_fd(2 * FRAME, "fd_0050");
    wait_an(4'b1110, 4, "digit0_0050");
    check("digit0_seg_0", 32'(seg), 32'h40);
    wait_an(4'b1101, SLOT + 2, "digit1_0050");
    check("digit1_seg_5", 32'(seg), 32'h12);
`ifndef SSD_LZB_EN
    wait_an(4'b0111, 2 * SLOT + 2, "digit3_0050");
    check("digit3_seg_0", 32'(seg), 32'h40);
`endif

    // Reset mid-frame discards a pending write
    repeat (3) @(negedge clk);
    write(16'h9999);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_discards_pending", 32'(wr_busy), 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n   = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 79) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 5) == 0) enable = 1'b1;
      wr_en   = ($urandom_range(0, 24) == 0);
      wr_data = 16'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1; wr_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
